isb_fetch_ctrl: RTL and testbench



---
 rtl/isb_pkg.sv | 15 +
 rtl/isb_credit_cnt.sv | 43 ++++
 rtl/isb_fetch_ctrl.sv | 100 ++++++++++
 tb/tb_isb_fetch_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isb_pkg.sv
// Shared definitions for the instruction stream buffer fetch path.
`timescale 1ns/1ps
package isb_pkg;
  localparam int ISB_DEPTH = 32;
  localparam int INSTR_W   = 16;
  localparam int PC_W      = 16;
  // Width used for buffered + in-flight occupancy sums; wide enough never to wrap.
  localparam int SUM_W     = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/isb_credit_cnt.sv
// In-flight / discard counter pair plus the issue-allowed credit compare.
`timescale 1ns/1ps
module isb_credit_cnt import isb_pkg::*; #(
  parameter int DEPTH   = ISB_DEPTH,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             grant,
  input  logic             rvalid,
  input  logic             redirect,
  input  logic [5:0]       buf_count,
  output logic [CNT_W-1:0] inflight,
  output logic [CNT_W-1:0] discard,
  output logic             rsp_ok,
  output logic             keep,
  output logic             room
);
  logic [SUM_W-1:0] used;

  // Buffered plus outstanding words must stay below the buffer size.
  assign used   = SUM_W'(buf_count) + SUM_W'(inflight);
  assign room   = (used < SUM_W'(DEPTH)) && (inflight < CNT_W'(MAX_OUT));
  // A response with nothing outstanding is ignored entirely.
  assign rsp_ok = rvalid && (inflight != '0);
  // Responses are kept only when nothing stale is ahead and no redirect is dropping them.
  assign keep   = rsp_ok && (discard == '0) && !redirect;

  // Track outstanding words and how many of them belong to a flushed stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight + CNT_W'(grant) - CNT_W'(rsp_ok);
      if (redirect)
        discard <= inflight - CNT_W'(rsp_ok);
      else if (rsp_ok && (discard != '0))
        discard <= discard - 1'b1;
    end
  end
endmodule

// File: rtl/isb_fetch_ctrl.sv
// Fetch sequencer keeping the ISB filled; flushes and restarts on redirect.
// Optional: define ISB_FETCH_PERF_EN to add saturating stall/discard counters.
`timescale 1ns/1ps
module isb_fetch_ctrl import isb_pkg::*; #(
  parameter int              DEPTH    = ISB_DEPTH,
  parameter int              MAX_OUT  = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               pause,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic [5:0]         buf_count,
  output logic               buf_push,
  output logic [INSTR_W-1:0] buf_data,
  output logic               buf_flush,
  output logic               busy
`ifdef ISB_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [15:0]        perf_discard_cnt
`endif
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  fetch_state_e     state;
  logic [PC_W-1:0]  pc;
  logic             flush_q;
  logic [CNT_W-1:0] inflight, discard;
  logic             rsp_ok, keep, room, fire, stale_left, drain_done;

  isb_credit_cnt #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_credit (
    .clk(clk), .rst_n(rst_n), .grant(fire), .rvalid(mem_rvalid),
    .redirect(redirect_valid), .buf_count(buf_count), .inflight(inflight),
    .discard(discard), .rsp_ok(rsp_ok), .keep(keep), .room(room)
  );

  // Redirect suppresses issue in its own cycle, which is how an ungranted request is withdrawn.
  assign mem_req    = (state == FETCH) && enable && !pause && !redirect_valid && room;
  assign fire       = mem_req && mem_gnt;
  assign mem_addr   = pc;
  assign buf_push   = keep;
  assign buf_data   = mem_rdata;
  assign buf_flush  = flush_q;
  assign busy       = (state != IDLE);
  // Words still owed by memory after this cycle's response belong to the old stream.
  assign stale_left = (inflight != CNT_W'(rsp_ok));
  assign drain_done = (discard == '0) || ((discard == CNT_W'(1)) && rsp_ok);

  // Fetch FSM, fetch PC and the flush pulse one cycle after a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      flush_q <= redirect_valid;
      if (redirect_valid) begin
        pc    <= redirect_pc;
        state <= stale_left ? DRAIN : FETCH;
      end else begin
        if (fire) pc <= pc + 1'b1;
        case (state)
          IDLE:    if (enable) state <= FETCH;
          FETCH:   if (!enable && (inflight == '0)) state <= IDLE;
          DRAIN:   if (drain_done) state <= FETCH;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ISB_FETCH_PERF_EN
  // Saturating counts of starved fetch cycles and of dropped responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt   <= '0;
      perf_discard_cnt <= '0;
    end else begin
      if ((state == FETCH) && enable && !mem_req && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (rsp_ok && !keep && (perf_discard_cnt != '1))
        perf_discard_cnt <= perf_discard_cnt + 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Memory must never return a word that was not requested.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rvalid |-> (inflight != '0));
`endif
endmodule

// File: tb/tb_isb_fetch_ctrl.sv
// Self-checking bench for isb_fetch_ctrl: memory model plus queue-based reference.
`timescale 1ns/1ps
module tb_isb_fetch_ctrl;
  logic        clk = 1'b0, rst_n;
  logic        enable, pause, redirect_valid, mem_gnt, mem_rvalid;
  logic [15:0] redirect_pc, mem_rdata, mem_addr, buf_data;
  logic [5:0]  buf_count;
  logic        mem_req, buf_push, buf_flush, busy;
`ifdef ISB_FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_discard_cnt;
`endif

  isb_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pause(pause),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .buf_count(buf_count),
    .buf_push(buf_push), .buf_data(buf_data), .buf_flush(buf_flush), .busy(busy)
`ifdef ISB_FETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_discard_cnt(perf_discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // Reference: every outstanding word with its address, stale flag and due cycle.
  typedef struct { logic [15:0] addr; bit stale; int due; } ent_t;
  ent_t        q[$];
  logic [15:0] m_pc;
  bit          m_on, m_flush, m_fetch;
  int          m_stall, m_disc;
  bit          e_req, e_push, e_flush, e_busy;
  logic [15:0] e_addr, e_data;
  int          gnt_pct, rsp_pct, lat_lo, lat_hi;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (q[i]) if (q[i].stale) n++;
    return n;
  endfunction

  // Memory drives grant/response, then the reference computes this cycle's outputs.
  task automatic settle();
    mem_gnt    = ($urandom_range(99) < gnt_pct);
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    if (q.size() > 0 && q[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(q[0].addr);
    end
    #1;
    m_fetch = m_on && (stale_cnt() == 0);
    e_req   = m_fetch && enable && !pause && !redirect_valid &&
              (int'(buf_count) + q.size() < 32) && (q.size() < 4);
    e_addr  = m_pc;
    e_push  = mem_rvalid && !q[0].stale && !redirect_valid;
    e_data  = mem_rvalid ? mem_word(q[0].addr) : 16'h0;
    e_flush = m_flush;
    e_busy  = m_on;
  endtask

  // Clock edge: retire responses, record grants, apply redirect and enable rules.
  task automatic advance();
    int  pre_size;
    bit  pre_fetch;
    @(posedge clk);
    pre_size  = q.size();
    pre_fetch = m_fetch;
    if (m_fetch && enable && !e_req) m_stall++;
    if (mem_rvalid && !e_push) m_disc++;
    if (mem_rvalid) void'(q.pop_front());
    if (e_req && mem_gnt) begin
      q.push_back('{m_pc, 1'b0, cyc + $urandom_range(lat_hi, lat_lo)});
      m_pc = m_pc + 16'd1;
    end
    if (redirect_valid) begin
      foreach (q[i]) q[i].stale = 1'b1;
      m_pc = redirect_pc;
      m_on = 1'b1;
    end else if (!m_on && enable) m_on = 1'b1;
    else if (pre_fetch && !enable && pre_size == 0) m_on = 1'b0;
    m_flush = redirect_valid;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 0; pause = 0; redirect_valid = 0; redirect_pc = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; buf_count = 0;
    q.delete(); m_pc = 16'h0000; m_on = 0; m_flush = 0; m_stall = 0; m_disc = 0;
    gnt_pct = 100; rsp_pct = 100; lat_lo = 2; lat_hi = 2;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1; pause = 0; redirect_valid = 0; redirect_pc = 0;
    mem_gnt = 1; mem_rvalid = 0; mem_rdata = 0; buf_count = 0;
    #2;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (buf_flush !== 1'b0 || buf_push !== 1'b0) begin errors++;
      $display("FAIL reset_buf got flush %b push %b want 0 0", buf_flush, buf_push); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", mem_addr); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [15:0] ga[$], pd[$];
    int gc[$];
    do_reset();
    enable = 1;
    for (int k = 0; k < 14; k++) begin
      settle();
      checks++; if (mem_req !== e_req || mem_addr !== e_addr) begin errors++;
        $display("FAIL b2b_req cyc %0d got %b/%h want %b/%h", cyc, mem_req, mem_addr, e_req, e_addr); end
      checks++; if (buf_push !== e_push) begin errors++;
        $display("FAIL b2b_push cyc %0d got %b want %b", cyc, buf_push, e_push); end
      if (mem_req && mem_gnt) begin ga.push_back(mem_addr); gc.push_back(cyc); end
      if (buf_push) pd.push_back(buf_data);
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= ga.size() || ga[i] !== 16'(i) || gc[i] !== gc[0] + i) begin errors++;
        $display("FAIL b2b_addr idx %0d got %h want %h back to back", i,
                 (i < ga.size()) ? ga[i] : 16'hxxxx, 16'(i)); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= pd.size() || pd[i] !== mem_word(16'(i))) begin errors++;
        $display("FAIL b2b_order idx %0d got %h want %h", i,
                 (i < pd.size()) ? pd[i] : 16'hxxxx, mem_word(16'(i))); end
    end
  endtask

  task automatic test_credit_limit();
    int ng = 0;
    do_reset();
    enable = 1; buf_count = 6'd30; rsp_pct = 0;
    for (int k = 0; k < 10; k++) begin
      settle(); if (mem_req && mem_gnt) ng++; advance();
    end
    checks++; if (ng !== 2) begin errors++; $display("FAIL credit_depth grants got %0d want 2", ng); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL credit_hold got %b want 0", mem_req); end
    buf_count = 6'd0; ng = 0;
    for (int k = 0; k < 8; k++) begin
      settle(); if (mem_req && mem_gnt) ng++; advance();
    end
    checks++; if (ng !== 2) begin errors++; $display("FAIL credit_maxout grants got %0d want 2", ng); end
  endtask

  task automatic test_redirect();
    int seen = 0;
    bit got = 0;
    do_reset();
    enable = 1; rsp_pct = 0; lat_lo = 1; lat_hi = 1;
    for (int k = 0; k < 20 && q.size() < 3; k++) begin settle(); advance(); end
    redirect_valid = 1; redirect_pc = 16'h0100;
    settle();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL redir_req got %b want 0", mem_req); end
    advance();
    redirect_valid = 0; rsp_pct = 100;
    for (int k = 0; k < 20 && seen < 3; k++) begin
      settle();
      if (k == 0) begin
        checks++; if (buf_flush !== 1'b1) begin errors++; $display("FAIL redir_flush got %b want 1", buf_flush); end
      end else begin
        checks++; if (buf_flush !== 1'b0) begin errors++; $display("FAIL redir_flush_pulse got %b want 0", buf_flush); end
      end
      checks++; if (mem_req !== e_req) begin errors++; $display("FAIL redir_drain_req got %b want %b", mem_req, e_req); end
      if (mem_rvalid) begin
        seen++;
        checks++; if (buf_push !== 1'b0) begin errors++; $display("FAIL redir_stale_push got %b want 0", buf_push); end
      end
      advance();
    end
    for (int k = 0; k < 10 && !got; k++) begin
      settle();
      if (mem_req) begin
        got = 1;
        checks++; if (mem_addr !== 16'h0100) begin errors++; $display("FAIL redir_addr got %h want 0100", mem_addr); end
      end
      advance();
    end
    checks++; if (!got) begin errors++; $display("FAIL redir_restart got no request want request"); end
  endtask

  task automatic test_pause();
    int np = 0;
    do_reset();
    enable = 1; rsp_pct = 0; lat_lo = 1; lat_hi = 1;
    for (int k = 0; k < 20 && q.size() < 2; k++) begin settle(); advance(); end
    pause = 1; rsp_pct = 100;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL pause_req got %b want 0", mem_req); end
      if (buf_push) begin
        checks++; if (buf_data !== e_data) begin errors++; $display("FAIL pause_data got %h want %h", buf_data, e_data); end
        np++;
      end
      advance();
    end
    checks++; if (np !== 2) begin errors++; $display("FAIL pause_pushes got %0d want 2", np); end
    pause = 0;
    settle();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin errors++;
      $display("FAIL pause_resume got %b/%h want 1/0002", mem_req, mem_addr); end
    advance();
  endtask

  task automatic test_pc_wrap();
    do_reset();
    enable = 1; gnt_pct = 0; redirect_valid = 1; redirect_pc = 16'hFFFF;
    settle(); advance();
    redirect_valid = 0; gnt_pct = 100;
    settle();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFF) begin errors++;
      $display("FAIL wrap_pre got %b/%h want 1/ffff", mem_req, mem_addr); end
    advance();
    settle();
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_post got %h want 0000", mem_addr); end
    advance();
  endtask

  task automatic test_redirect_with_rsp();
    do_reset();
    enable = 1; rsp_pct = 0; lat_lo = 1; lat_hi = 1;
    for (int k = 0; k < 10 && q.size() < 1; k++) begin settle(); advance(); end
    gnt_pct = 0; rsp_pct = 100; redirect_valid = 1; redirect_pc = 16'h0200;
    settle();
    checks++; if (!mem_rvalid || buf_push !== 1'b0) begin errors++;
      $display("FAIL redir_rsp_drop got rvalid %b push %b want 1 0", mem_rvalid, buf_push); end
    advance();
    redirect_valid = 0; gnt_pct = 100;
    settle();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200 || buf_flush !== 1'b1) begin errors++;
      $display("FAIL redir_rsp_fetch got %b/%h/%b want 1/0200/1", mem_req, mem_addr, buf_flush); end
    advance();
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1; rsp_pct = 0;
    repeat (4) begin settle(); advance(); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 16'h0000) begin errors++;
      $display("FAIL async_reset got %b/%b/%h want 0/0/0000", mem_req, busy, mem_addr); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    gnt_pct = 70; rsp_pct = 60; lat_lo = 1; lat_hi = 4;
    for (int k = 0; k < 3000; k++) begin
      enable         = ((k % 300) < 240) ? ($urandom_range(99) < 95) : 1'b0;
      pause          = ($urandom_range(99) < 15);
      redirect_valid = ($urandom_range(99) < 4);
      redirect_pc    = 16'($urandom);
      buf_count      = 6'($urandom_range(32));
      settle();
      checks++; if (mem_req !== e_req) begin errors++; $display("FAIL rnd_req cyc %0d got %b want %b", cyc, mem_req, e_req); end
      checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, mem_addr, e_addr); end
      checks++; if (buf_push !== e_push) begin errors++; $display("FAIL rnd_push cyc %0d got %b want %b", cyc, buf_push, e_push); end
      if (e_push) begin
        checks++; if (buf_data !== e_data) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", cyc, buf_data, e_data); end
      end
      checks++; if (buf_flush !== e_flush) begin errors++; $display("FAIL rnd_flush cyc %0d got %b want %b", cyc, buf_flush, e_flush); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, busy, e_busy); end
      advance();
    end
`ifdef ISB_FETCH_PERF_EN
    checks++; if (perf_stall_cnt !== 32'(m_stall)) begin errors++;
      $display("FAIL perf_stall got %0d want %0d", perf_stall_cnt, m_stall); end
    checks++; if (perf_discard_cnt !== 16'(m_disc)) begin errors++;
      $display("FAIL perf_discard got %0d want %0d", perf_discard_cnt, m_disc); end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_credit_limit();
    test_redirect();
    test_pause();
    test_pc_wrap();
    test_redirect_with_rsp();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
